first_nios2_system_sysid_checker: RTL and testbench
===================================================

FIRST_NIOS2_SYSTEM_SYSID_CHECKER -- requirements
Module: first_nios2_system_sysid_checker

Interface
REQ-001 Parameter: EXPECTED_ID, default 0, 32-bit value required at slave word 0.
REQ-002 Parameter: EXPECTED_TIMESTAMP, default 1539280650 (0x5BBF8F0A), 32-bit value required at slave word 1.
REQ-003 Parameter: TIMEOUT_CYCLES, default 255, maximum stalled cycles per read; legal range 1..65535.
REQ-004 Port: clock  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  request one check sequence; sampled only in IDLE.
REQ-007 Port: avm_address  output  1  Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-008 Port: avm_read  output  1  Avalon-MM read strobe.
REQ-009 Port: avm_waitrequest  input  1  slave stall; read accepted in a cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 Port: avm_readdata  input  32  read data, valid in the accepting cycle (zero read latency).
REQ-011 Port: busy  output  1  high while a sequence is in progress.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: pass  output  1  last sequence matched both words.
REQ-014 Port: error_code  output  2  00 ok, 01 ID mismatch, 10 timestamp mismatch, 11 timeout.
REQ-015 Port: id_value  output  32  captured word 0.
REQ-016 Port: timestamp_value  output  32  captured word 1.

Function
REQ-017 States SHALL be IDLE, READ_ID, READ_TS, DONE; one-hot or binary encoding at implementer's choice.
REQ-018 IDLE: avm_read=0, busy=0; start=1 -> READ_ID, clear timeout counter; start=0 -> stay.
REQ-019 READ_ID: avm_read=1, avm_address=0, busy=1; on acceptance capture avm_readdata into id_value -> READ_TS, clear timeout counter.
REQ-020 READ_TS: avm_read=1, avm_address=1, busy=1; on acceptance capture avm_readdata into timestamp_value -> DONE.
REQ-021 avm_address and avm_read SHALL be registered and SHALL stay constant while avm_waitrequest=1.
REQ-022 Timeout counter (16-bit) SHALL increment each READ_ID/READ_TS cycle with avm_waitrequest=1; on reaching TIMEOUT_CYCLES the read is abandoned -> DONE with error_code=11, pass=0; captured value of the abandoned word unchanged.
REQ-023 Acceptance in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as acceptance, not timeout.
REQ-024 On entry to DONE without timeout: pass=1 and error_code=00 iff both words match; ID mismatch -> 01 (takes precedence over timestamp mismatch); else timestamp mismatch -> 10.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, avm_read=0; unconditional -> IDLE; start in DONE ignored.
REQ-026 pass, error_code, id_value, timestamp_value SHALL hold until updated by a later sequence; start clears pass and error_code on entry to READ_ID.
REQ-027 Latency with avm_waitrequest=0: start sampled at edge N -> READ_ID cycle N+1, READ_TS cycle N+2, done=1 cycle N+3, start next accepted at edge N+4.
REQ-028 start asserted while busy or in DONE SHALL be ignored, not queued.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and avm_read=0, avm_address=0, busy=0, done=0, pass=0, error_code=00, id_value=0, timestamp_value=0, timeout counter=0.
REQ-030 reset SHALL override start and any in-flight read (mid-stall abort, no done pulse).
REQ-031 The block SHALL not rely on any reset value of avm_readdata or avm_waitrequest.

Verification
REQ-032 Matching slave (word0=0, word1=1539280650), waitrequest=0, one-cycle start -> done at cycle N+3, pass=1, error_code=00, timestamp_value=1539280650.
REQ-033 Slave word1=1539280651 -> done, pass=0, error_code=10; word0=5 and word1 wrong -> error_code=01.
REQ-034 waitrequest=1 for 3 cycles on each read -> address/read stable throughout, done 9 cycles after start, pass=1.
REQ-035 TIMEOUT_CYCLES=4, waitrequest stuck at 1 in READ_TS -> done after 4 stalled cycles, error_code=11, id_value captured, timestamp_value unchanged.
REQ-036 reset pulsed during READ_ID stall -> next cycle all outputs at reset values, no done pulse; start held high during sequence -> exactly one sequence per IDLE entry.

Source files
------------

// File: rtl/first_nios2_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system ID peripheral (slave).
//   avm_address     : word address, 0 = ID, 1 = timestamp (master -> slave)
//   avm_read        : read strobe (master -> slave)
//   avm_waitrequest : slave stall (slave -> master)
//   avm_readdata    : zero-latency read data (slave -> master)
interface first_nios2_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the system ID peripheral (word 0 = ID, word 1 = timestamp) over
// Avalon-MM and compares both words against the expected build values.
// Ports:
//   clock, reset    : single rising-edge clock, synchronous active-high reset
//   start           : request one check sequence (sampled only when idle)
//   avm             : Avalon-MM master port (registered address/read)
//   busy            : sequence in progress
//   done            : one-cycle completion pulse
//   pass            : last sequence matched both words
//   error_code      : 00 ok, 01 ID mismatch, 10 timestamp mismatch, 11 timeout
//   id_value        : last captured word 0
//   timestamp_value : last captured word 1
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1539280650,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  first_nios2_system_sysid_checker_if.master     avm,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   pass,
  output logic [1:0]                             error_code,
  output logic [31:0]                            id_value,
  output logic [31:0]                            timestamp_value
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrId      = 2'b01;
  localparam logic [1:0] ErrTs      = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StReadId,
    StReadTs,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tmo_inc;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        pass_q, pass_d;
  logic [1:0]  err_q, err_d;
  logic        read_q, addr_q, busy_q, done_q;

  assign tmo_inc = tmo_q + 16'd1;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;
    pass_d  = pass_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReadId;
          tmo_d   = 16'd0;
          pass_d  = 1'b0;
          err_d   = ErrOk;
        end
      end
      StReadId: begin
        if (!avm.avm_waitrequest) begin
          id_d    = avm.avm_readdata;
          state_d = StReadTs;
          tmo_d   = 16'd0;
        end else begin
          tmo_d = tmo_inc;
          // Abandon on the stalled cycle that brings the count to the limit.
          if (tmo_inc == TimeoutLimit) begin
            state_d = StDone;
            pass_d  = 1'b0;
            err_d   = ErrTimeout;
          end
        end
      end
      StReadTs: begin
        if (!avm.avm_waitrequest) begin
          ts_d    = avm.avm_readdata;
          state_d = StDone;
          tmo_d   = 16'd0;
          // ID mismatch is reported in preference to a timestamp mismatch.
          if (id_q != EXPECTED_ID) begin
            err_d = ErrId;
          end else if (avm.avm_readdata != EXPECTED_TIMESTAMP) begin
            err_d = ErrTs;
          end else begin
            err_d  = ErrOk;
            pass_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TimeoutLimit) begin
            state_d = StDone;
            pass_d  = 1'b0;
            err_d   = ErrTimeout;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus and status outputs are registered from the next state so they change
  // only at state transitions and hold steady through a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tmo_q   <= 16'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      pass_q  <= 1'b0;
      err_q   <= ErrOk;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      read_q  <= (state_d == StReadId) || (state_d == StReadTs);
      addr_q  <= (state_d == StReadTs);
      busy_q  <= (state_d == StReadId) || (state_d == StReadTs);
      done_q  <= (state_d == StDone);
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_code      = err_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
module tb_first_nios2_system_sysid_checker;

  localparam int          T      = 4;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1539280650;

  logic        clock;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  error_code;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;

  first_nios2_system_sysid_checker_if bus ();

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_code     (error_code),
    .id_value       (id_value),
    .timestamp_value(timestamp_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model of the architecturally visible result registers.
  logic [31:0] m_id;
  logic [31:0] m_ts;
  logic        m_pass;
  logic [1:0]  m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, ".pass"}, {31'd0, pass}, {31'd0, m_pass});
    chk({tag, ".err"}, {30'd0, error_code}, {30'd0, m_err});
    chk({tag, ".id"}, id_value, m_id);
    chk({tag, ".ts"}, timestamp_value, m_ts);
  endtask

  // One check sequence against a slave that stalls s0 / s1 cycles on the
  // ID / timestamp reads and returns d0 / d1. With hold set, start stays high
  // until the done cycle.
  task automatic run_seq(input string tag, input int s0, input int s1,
                         input logic [31:0] d0, input logic [31:0] d1, input bit hold);
    int   exp_k;
    int   stall;
    int   s_cur;
    bit   prev_stall;
    logic prev_addr;
    logic wr;

    // Expected completion offset (cycles after the start-sampling edge) and result.
    if (s0 >= T) begin
      exp_k  = T + 1;
      m_pass = 1'b0;
      m_err  = 2'b11;
    end else if (s1 >= T) begin
      exp_k  = s0 + 1 + T + 1;
      m_id   = d0;
      m_pass = 1'b0;
      m_err  = 2'b11;
    end else begin
      exp_k = s0 + s1 + 3;
      m_id  = d0;
      m_ts  = d1;
      if (d0 != EXP_ID)      m_err = 2'b01;
      else if (d1 != EXP_TS) m_err = 2'b10;
      else                   m_err = 2'b00;
      m_pass = (m_err == 2'b00);
    end

    @(negedge clock);
    start = 1'b1;
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata    = $urandom;
    @(posedge clock);
    stall      = 0;
    prev_stall = 1'b0;
    prev_addr  = 1'b0;
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      if (k < exp_k) begin
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".nodone"}, {31'd0, done}, 32'd0);
        if (prev_stall && stall < T) begin
          chk({tag, ".rd_stable"}, {31'd0, bus.avm_read}, 32'd1);
          chk({tag, ".addr_stable"}, {31'd0, bus.avm_address}, {31'd0, prev_addr});
        end
      end else begin
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ".rd_done"}, {31'd0, bus.avm_read}, 32'd0);
        chk_results(tag);
        start = 1'b0;
      end
      if (k < exp_k) begin
        if (bus.avm_read) begin
          s_cur = bus.avm_address ? s1 : s0;
          wr    = (stall < s_cur);
          bus.avm_waitrequest = wr;
          bus.avm_readdata    = wr ? $urandom : (bus.avm_address ? d1 : d0);
        end else begin
          wr = 1'b0;
          bus.avm_waitrequest = 1'($urandom_range(0, 1));
          bus.avm_readdata    = $urandom;
        end
        prev_stall = bus.avm_read && wr;
        prev_addr  = bus.avm_address;
        @(posedge clock);
        if (prev_stall)        stall++;
        else if (bus.avm_read) stall = 0;
      end
    end
    // done lasts one cycle and a start held into DONE must not relaunch.
    @(negedge clock);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clock);
    chk({tag, ".idle_busy2"}, {31'd0, busy}, 32'd0);
    chk_results({tag, ".hold"});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'hdead_beef;
    m_id   = 32'd0;
    m_ts   = 32'd0;
    m_pass = 1'b0;
    m_err  = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.rd", {31'd0, bus.avm_read}, 32'd0);
    chk("rst.addr", {31'd0, bus.avm_address}, 32'd0);
    chk_results("rst");
    reset = 1'b0;

    run_seq("match", 0, 0, EXP_ID, EXP_TS, 1'b0);
    run_seq("ts_bad", 0, 0, EXP_ID, EXP_TS + 32'd1, 1'b0);
    run_seq("id_bad", 0, 0, 32'd5, EXP_TS + 32'd1, 1'b0);
    run_seq("stall3", 3, 3, EXP_ID, EXP_TS, 1'b0);
    run_seq("tmo_ts", 0, 50, 32'h0000_1234, EXP_TS, 1'b0);
    run_seq("tmo_id", 9, 0, 32'h0000_5678, EXP_TS, 1'b0);
    run_seq("hold", 1, 2, EXP_ID, EXP_TS, 1'b1);

    // Reset mid-stall in READ_ID with start asserted.
    @(negedge clock);
    start = 1'b1;
    bus.avm_waitrequest = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    m_id   = 32'd0;
    m_ts   = 32'd0;
    m_pass = 1'b0;
    m_err  = 2'b00;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.done", {31'd0, done}, 32'd0);
    chk("rst_mid.rd", {31'd0, bus.avm_read}, 32'd0);
    chk("rst_mid.addr", {31'd0, bus.avm_address}, 32'd0);
    chk_results("rst_mid");
    repeat (3) begin
      @(negedge clock);
      chk("rst_mid.nodone", {31'd0, done}, 32'd0);
    end
    bus.avm_waitrequest = 1'b0;

    for (int i = 0; i < 30; i++) begin
      int          s0;
      int          s1;
      logic [31:0] d0;
      logic [31:0] d1;
      s0 = $urandom_range(0, 5);
      s1 = $urandom_range(0, 5);
      d0 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : EXP_ID;
      d1 = ($urandom_range(0, 2) == 0) ? (EXP_TS ^ (32'd1 << $urandom_range(0, 31))) : EXP_TS;
      run_seq("rand", s0, s1, d0, d1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
